// File: rtl/tt_um_sunaofurukawa_prog_seq.sv
// Programmable word sequencer: buffers a short program of {operand, opcode} bytes and
// replays it to a downstream 8-bit CPU with the operand skewed one word later than its opcode.
module tt_um_sunaofurukawa_prog_seq #(
    parameter int         DEPTH   = 16,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in8bit,
    input  logic       load,
    input  logic       clr,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] out8bit,
    output logic       busy,
    output logic       done,
    output logic       prog_full
);

    localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_1  = CW'(1);
    localparam logic [AW-1:0] PC_1   = AW'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [3:0]    pend, pend_nxt;
    logic [7:0]    out_nxt;
    logic [7:0]    word;
    logic          wr_en;
    logic          last;

    assign word = mem[pc];
    assign last = ({{(CW-AW){1'b0}}, pc} == (cnt - CNT_1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = pc;
        pend_nxt  = pend;
        out_nxt   = out8bit;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                out_nxt = 8'h00;
                if (clr) begin
                    cnt_nxt = '0;
                end else if (load) begin
                    if (cnt != FULL) begin
                        wr_en   = 1'b1;
                        cnt_nxt = cnt + CNT_1;
                    end
                end else if (start && (cnt != '0)) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    pend_nxt  = '0;
                end
            end
            RUN: begin
                // A pause flushes the pending operand so the resumed word carries operand 0
                if (pause) begin
                    out_nxt  = {pend, 4'h0};
                    pend_nxt = '0;
                end else if (word[3:0] == HALT_OP) begin
                    state_nxt = FLUSH;
                end else begin
                    out_nxt  = {pend, word[3:0]};
                    pend_nxt = word[7:4];
                    if (last) begin
                        state_nxt = FLUSH;
                    end else begin
                        pc_nxt = pc + PC_1;
                    end
                end
            end
            FLUSH: begin
                out_nxt   = {pend, 4'h0};
                state_nxt = DONE;
            end
            DONE: begin
                out_nxt   = 8'h00;
                pc_nxt    = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pc        <= '0;
            pend      <= '0;
            out8bit   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            prog_full <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pc        <= pc_nxt;
            pend      <= pend_nxt;
            out8bit   <= out_nxt;
            // Status flags travel with the word produced by the same state
            busy      <= (state == RUN) || (state == FLUSH);
            done      <= (state == DONE);
            prog_full <= (cnt_nxt == FULL);
        end
    end

    // Program storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt[AW-1:0]] <= in8bit;
        end
    end

endmodule

// File: tb/tb_tt_um_sunaofurukawa_prog_seq.sv
// Directed testbench for the program sequencer: load, run, halt, pause, overflow, ignored controls, reset.
module tb_tt_um_sunaofurukawa_prog_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] in8bit;
    logic       load;
    logic       clr;
    logic       start;
    logic       pause;
    logic [7:0] out8bit;
    logic       busy;
    logic       done;
    logic       prog_full;

    int checks = 0;
    int passes = 0;

    tt_um_sunaofurukawa_prog_seq #(.DEPTH(16), .HALT_OP(4'hF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in8bit    (in8bit),
        .load      (load),
        .clr       (clr),
        .start     (start),
        .pause     (pause),
        .out8bit   (out8bit),
        .busy      (busy),
        .done      (done),
        .prog_full (prog_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] w);
        load   = 1'b1;
        in8bit = w;
        tick();
        load   = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in8bit = 8'h00; load = 1'b0; clr = 1'b0; start = 1'b0; pause = 1'b0;
        tick();
        tick();
        checks++;
        if (out8bit !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || prog_full !== 1'b0) begin
            $display("FAIL reset_state out=%h busy=%b done=%b full=%b, required 00 0 0 0",
                     out8bit, busy, done, prog_full);
        end else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_run();
        logic [7:0] eo [4];
        logic [0:3] eb;
        logic [0:3] ed;
        eo = '{8'h01, 8'h32, 8'h50, 8'h00};
        eb = 4'b1110;
        ed = 4'b0001;
        do_clr();
        load_word(8'h31);
        load_word(8'h52);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out8bit !== eo[i] || busy !== eb[i] || done !== ed[i]) begin
                $display("FAIL basic_run[%0d] got out=%h busy=%b done=%b, required out=%h busy=%b done=%b",
                         i, out8bit, busy, done, eo[i], eb[i], ed[i]);
            end else passes++;
        end
        tick();
        checks++;
        if (out8bit !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL basic_idle got out=%h busy=%b done=%b, required 00 0 0", out8bit, busy, done);
        end else passes++;
    endtask

    task automatic test_halt();
        logic [7:0] eo [5];
        logic [0:4] eb;
        logic [0:4] ed;
        eo = '{8'h01, 8'h01, 8'h30, 8'h00, 8'h00};
        eb = 5'b11100;
        ed = 5'b00010;
        do_clr();
        load_word(8'h31);
        load_word(8'h0F);
        load_word(8'h52);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out8bit !== eo[i] || busy !== eb[i] || done !== ed[i]) begin
                $display("FAIL halt[%0d] got out=%h busy=%b done=%b, required out=%h busy=%b done=%b",
                         i, out8bit, busy, done, eo[i], eb[i], ed[i]);
            end else passes++;
        end
    endtask

    task automatic test_pause();
        logic [7:0] eo [6];
        logic [0:5] eb;
        logic [0:5] ed;
        eo = '{8'h01, 8'h30, 8'h00, 8'h02, 8'h50, 8'h00};
        eb = 6'b111110;
        ed = 6'b000001;
        do_clr();
        load_word(8'h31);
        load_word(8'h52);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            pause = (i == 1 || i == 2);
            tick();
            checks++;
            if (out8bit !== eo[i] || busy !== eb[i] || done !== ed[i]) begin
                $display("FAIL pause[%0d] got out=%h busy=%b done=%b, required out=%h busy=%b done=%b",
                         i, out8bit, busy, done, eo[i], eb[i], ed[i]);
            end else passes++;
        end
        pause = 1'b0;
    endtask

    task automatic test_full_overflow();
        logic [7:0] exp_w;
        int         bad;
        do_clr();
        for (int k = 0; k < 16; k++) begin
            load_word({4'(k), 1'b0, 3'(k)});
            if (k == 14) begin
                checks++;
                if (prog_full !== 1'b0) $display("FAIL full_at_15 got %b, required 0", prog_full);
                else passes++;
            end
        end
        checks++;
        if (prog_full !== 1'b1) $display("FAIL full_at_16 got %b, required 1", prog_full);
        else passes++;
        load_word(8'hAB);
        checks++;
        if (prog_full !== 1'b1) $display("FAIL full_after_17 got %b, required 1", prog_full);
        else passes++;
        pulse_start();
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            exp_w = {(k == 0) ? 4'h0 : 4'(k - 1), 1'b0, 3'(k)};
            tick();
            if (bad == 0 && (out8bit !== exp_w || busy !== 1'b1 || done !== 1'b0)) begin
                $display("FAIL full_run[%0d] got out=%h busy=%b done=%b, required out=%h busy=1 done=0",
                         k, out8bit, busy, done, exp_w);
                bad = 1;
            end
        end
        checks++;
        if (bad == 0) passes++;
        tick();
        checks++;
        if (out8bit !== 8'hF0 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL full_flush got out=%h busy=%b done=%b, required F0 1 0", out8bit, busy, done);
        end else passes++;
        tick();
        checks++;
        if (out8bit !== 8'h00 || busy !== 1'b0 || done !== 1'b1) begin
            $display("FAIL full_done got out=%h busy=%b done=%b, required 00 0 1", out8bit, busy, done);
        end else passes++;
        do_clr();
        checks++;
        if (prog_full !== 1'b0) $display("FAIL full_clr got %b, required 0", prog_full);
        else passes++;
    endtask

    task automatic test_ignored_controls();
        logic [7:0] eo [4];
        logic [0:3] eb;
        logic [0:3] ed;
        eo = '{8'h02, 8'h43, 8'h10, 8'h00};
        eb = 4'b1110;
        ed = 4'b0001;
        do_clr();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || out8bit !== 8'h00) begin
                $display("FAIL start_empty[%0d] got busy=%b out=%h, required 0 00", i, busy, out8bit);
            end else passes++;
        end
        load_word(8'h42);
        load = 1'b1; start = 1'b1; in8bit = 8'h13;
        tick();
        load = 1'b0; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || out8bit !== 8'h00) begin
                $display("FAIL load_start[%0d] got busy=%b out=%h, required 0 00", i, busy, out8bit);
            end else passes++;
        end
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            for (int i = 0; i < 4; i++) begin
                load   = (r == 0 && i == 0);
                in8bit = 8'h77;
                tick();
                checks++;
                if (out8bit !== eo[i] || busy !== eb[i] || done !== ed[i]) begin
                    $display("FAIL run_load%0d[%0d] got out=%h busy=%b done=%b, required out=%h busy=%b done=%b",
                             r, i, out8bit, busy, done, eo[i], eb[i], ed[i]);
                end else passes++;
            end
            load = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        int saw_done;
        do_clr();
        load_word(8'h31);
        load_word(8'h52);
        pulse_start();
        tick();
        checks++;
        if (out8bit !== 8'h01 || busy !== 1'b1) begin
            $display("FAIL rst_pre got out=%h busy=%b, required 01 1", out8bit, busy);
        end else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out8bit !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL rst_async got out=%h busy=%b done=%b, required 00 0 0", out8bit, busy, done);
        end else passes++;
        tick();
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done !== 1'b0) saw_done = 1;
        end
        checks++;
        if (saw_done != 0) $display("FAIL rst_no_done got done pulse, required none");
        else passes++;
        pulse_start();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || out8bit !== 8'h00) begin
            $display("FAIL rst_start_empty got busy=%b out=%h, required 0 00", busy, out8bit);
        end else passes++;
        load_word(8'h31);
        pulse_start();
        tick();
        checks++;
        if (out8bit !== 8'h01 || busy !== 1'b1) begin
            $display("FAIL rst_reload got out=%h busy=%b, required 01 1", out8bit, busy);
        end else passes++;
        tick();
        tick();
        checks++;
        if (out8bit !== 8'h00 || done !== 1'b1) begin
            $display("FAIL rst_reload_done got out=%h done=%b, required 00 1", out8bit, done);
        end else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_halt();
        test_pause();
        test_full_overflow();
        test_ignored_controls();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
